oled_write_queue: RTL

AHB-Lite slave FIFO that buffers software-issued OLED commands and display data and presents them, one entry at a time, on a valid/ready stream to the OLED serializer immediately downstream. Software issues a burst of bus writes without polling a per-transfer ready flag; the queue drains at the serializer's pace. It sits on the AHB decoder as the OLED slave and owns the only path from the CPU to the serializer.

---
 rtl/oled_write_queue.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/oled_write_queue.sv
// oled_write_queue
//
// AHB-Lite slave that queues OLED commands and display data for the serializer.
// Software writes entries through three push registers. The queue presents the
// oldest entry on a show-ahead valid/ready stream.
//
// Entry format: {dnc, wide, data[15:0]}
//   dnc  = 0 command, 1 display data
//   wide = 0 send data[7:0], 1 send data[15:0]
//
// Register map (offset = HADDR[3:2] * 4)
//   0x0 W : push 8-bit command       {0, 0, HWDATA[7:0]}
//   0x4 W : push 8-bit display data  {1, 0, HWDATA[7:0]}
//   0x8 W : push 16-bit command      {0, 1, HWDATA[15:0]}
//   0xC R : status {count @ [8+CW-1:8], overflow @2, full @1, empty @0}
//   0xC W : bit0 clears overflow, bit1 flushes the queue
//
// Ports
//   HCLK, HRESETn              clock, asynchronous active-low reset
//   HSEL, HREADY, HWRITE,
//   HADDR, HWDATA, HSIZE,
//   HTRANS                     AHB-Lite slave inputs (HSIZE ignored)
//   HRDATA, HREADYOUT          AHB-Lite slave outputs (zero wait states)
//   OUT_VALID, OUT_DNC,
//   OUT_WIDE, OUT_DATA         head entry towards the serializer
//   OUT_READY                  serializer accepts the head entry
module oled_write_queue #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        OUT_VALID,
  output logic        OUT_DNC,
  output logic        OUT_WIDE,
  output logic [15:0] OUT_DATA,
  input  logic        OUT_READY
);

  localparam int AW = $clog2(DEPTH);

  // Registered address-phase decode, consumed during the data phase.
  logic          dph_valid_reg;
  logic          dph_write_reg;
  logic [1:0]    dph_addr_reg;

  // Queue state.
  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;

  // Data-phase actions.
  logic          wr_cmd;
  logic          push_req;
  logic          ctrl_wr;
  logic          flush;
  logic          ov_clear;
  logic          ov_set;
  logic          push_ok;
  logic          pop;
  logic          out_valid;
  logic          full;
  logic [17:0]   push_entry;
  logic [17:0]   head;
  logic [31:0]   status;

  // Bus fields this slave never looks at.
  logic          unused_bits;
  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

  assign HREADYOUT = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_valid_reg <= 1'b0;
      dph_write_reg <= 1'b0;
      dph_addr_reg  <= 2'd0;
    end else begin
      dph_valid_reg <= HSEL && HREADY && (HTRANS != 2'b00);
      dph_write_reg <= HWRITE;
      dph_addr_reg  <= HADDR[3:2];
    end
  end

  assign wr_cmd    = dph_valid_reg && dph_write_reg;
  assign push_req  = wr_cmd && (dph_addr_reg != 2'd3);
  assign ctrl_wr   = wr_cmd && (dph_addr_reg == 2'd3);
  assign flush     = ctrl_wr && HWDATA[1];
  assign ov_clear  = ctrl_wr && HWDATA[0];

  assign out_valid = (count_reg != '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign pop       = out_valid && OUT_READY;

  // A pop in the same cycle frees a slot, so a full queue still accepts.
  // A flush discards the push without flagging overflow.
  assign push_ok   = push_req && (!full || pop) && !flush;
  assign ov_set    = push_req && full && !pop && !flush;

  always_comb begin
    push_entry = '0;
    case (dph_addr_reg)
      2'd0:    push_entry = {2'b00, 8'h00, HWDATA[7:0]};
      2'd1:    push_entry = {2'b10, 8'h00, HWDATA[7:0]};
      default: push_entry = {2'b01, HWDATA[15:0]};
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
        if (push_ok) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        case ({push_ok, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
      // A new overflow beats a same-cycle clear.
      if (ov_set) begin
        overflow_reg <= 1'b1;
      end else if (ov_clear) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Show-ahead head; payload forced to zero while nothing is queued.
  assign head      = mem[rd_ptr_reg];
  assign OUT_VALID = out_valid;
  assign OUT_DNC   = out_valid & head[17];
  assign OUT_WIDE  = out_valid & head[16];
  assign OUT_DATA  = out_valid ? head[15:0] : 16'h0000;

  always_comb begin
    status          = '0;
    status[0]       = ~out_valid;
    status[1]       = full;
    status[2]       = overflow_reg;
    status[8 +: CW] = count_reg;
  end

  always_comb begin
    HRDATA = 32'h0000_0000;
    if (dph_valid_reg && !dph_write_reg && (dph_addr_reg == 2'd3)) begin
      HRDATA = status;
    end
  end

endmodule
